// File: rtl/spi_input_conditioner.sv
// Conditions the raw SPI pins into the s_clk domain: 2-flop synchroniser plus
// debounce filter per pin, with registered 1-cycle edge pulses for SCLK and CS.
module spi_input_conditioner #(
  parameter int COUNTER_WIDTH = 3,
  parameter int WAIT_TIME     = 3
) (
  input  logic s_clk,
  input  logic reset,
  input  logic sclk_pin,
  input  logic cs_pin,
  input  logic mosi_pin,
  output logic sclk_q,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_q,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_q
);

  localparam logic [COUNTER_WIDTH-1:0] WAIT_C  = COUNTER_WIDTH'(WAIT_TIME);
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);
  // Channel index: 0 = SCLK, 1 = CS (idles high), 2 = MOSI.
  localparam logic [2:0] RST_LVL = 3'b010;

  logic [2:0] pin_w;
  logic [2:0] sync0_q;
  logic [2:0] sync1_q;
  logic [2:0] level_q;
  logic [2:0] level_d;
  logic [COUNTER_WIDTH-1:0] cnt_q [3];
  logic [COUNTER_WIDTH-1:0] cnt_d [3];
  logic [1:0] rise_q;
  logic [1:0] rise_d;
  logic [1:0] fall_q;
  logic [1:0] fall_d;

  assign pin_w = {mosi_pin, cs_pin, sclk_pin};

  // Any sample matching the accepted level restarts the count, so a change needs
  // WAIT_TIME+1 consecutive differing samples; the counter clears on acceptance.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync1_q[i] != level_q[i]) begin
        if (cnt_q[i] == WAIT_C) begin
          level_d[i] = sync1_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
    rise_d = level_d[1:0] & ~level_q[1:0];
    fall_d = ~level_d[1:0] & level_q[1:0];
  end

  always_ff @(posedge s_clk or posedge reset) begin
    if (reset) begin
      sync0_q <= RST_LVL;
      sync1_q <= RST_LVL;
      level_q <= RST_LVL;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync0_q <= pin_w;
      sync1_q <= sync0_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign sclk_q    = level_q[0];
  assign sclk_rise = rise_q[0];
  assign sclk_fall = fall_q[0];
  assign cs_q      = level_q[1];
  assign cs_rise   = rise_q[1];
  assign cs_fall   = fall_q[1];
  assign mosi_q    = level_q[2];

endmodule
